ram_sync: RTL and testbench
===========================

Name: ram_sync

Overview:
Parametrised, clocked successor to the processor's data RAM. It replaces the asynchronous bidirectional-bus memory with separate write and read data ports and a registered read with a valid strobe. An optional post-reset clear sequencer zeroes every location before the first access is accepted. It sits between the decoder's chips/enableRW strobes and the datapath, and keeps the {oprnd, program_byte} address concatenation that the program counter consumes.

Parameters:
DATA_WIDTH, 4, width of one memory word.
ADDR_HI_WIDTH, 4, width of oprnd, which forms the upper address field.
ADDR_LO_WIDTH, 8, width of program_byte, which forms the lower address field.
ADDR_WIDTH, ADDR_HI_WIDTH+ADDR_LO_WIDTH (derived, localparam), full address width.
DEPTH, 2**ADDR_WIDTH (derived, localparam), number of words.
CLEAR_ON_RESET, 1, 1 = zero all words after reset; 0 = contents untouched and ready immediately.

Ports:
clock  in  1  rising-edge clock.
reset  in  1  synchronous, active-high reset.
chips  in  1  access request, sampled at the rising edge.
enableRW  in  1  1 = write, 0 = read; qualified by chips.
oprnd  in  ADDR_HI_WIDTH  upper address field.
program_byte  in  ADDR_LO_WIDTH  lower address field.
wdata  in  DATA_WIDTH  write data.
rdata  out  DATA_WIDTH  registered read data.
rvalid  out  1  one-cycle pulse; rdata is valid.
busy  out  1  clear in progress; accesses are ignored.
address  out  ADDR_WIDTH  combinational {oprnd, program_byte}.

Behaviour:
- address = {oprnd, program_byte} at all times, combinational, independent of reset.
- Reset values, held while reset is high: rdata=0, rvalid=0, clear counter=0. busy=1 if CLEAR_ON_RESET=1, else 0.
- State machine, two states:
  - CLEAR: one word per clock, mem[cnt]<=0 and cnt<=cnt+1. Runs for DEPTH cycles after reset deasserts. At cnt==DEPTH-1 the write happens and the state becomes IDLE. busy=1 throughout CLEAR.
  - IDLE: busy=0. Entered directly from reset when CLEAR_ON_RESET=0.
- Write: edge with chips=1, enableRW=1, busy=0 -> mem[address]<=wdata. rvalid=0 on the next cycle; rdata unchanged.
- Read: edge with chips=1, enableRW=0, busy=0 -> next cycle rdata=mem[address] and rvalid=1. Latency is exactly 1 cycle.
- Back-to-back reads: one per cycle; rvalid stays high continuously.
- No access on an edge -> rvalid=0 next cycle; rdata holds its last value.
- Single port, so no read/write collision. A read at the cycle after a write to the same address returns the new data.
- chips during busy: dropped, not queued. Memory is not written and rvalid is not produced.
- Reset mid-CLEAR or mid-access: the counter restarts from 0 and the whole clear reruns. An in-flight read's rvalid is suppressed by reset.
- Counter width is ADDR_WIDTH+1 so DEPTH is representable; no wrap inside CLEAR.
- Address arithmetic is unsigned. There is no out-of-range case because DEPTH = 2**ADDR_WIDTH.
- No tristate or inout ports; bus muxing is outside this block.
- Memory contents are not reset when CLEAR_ON_RESET=0 and are X in simulation until written.

Decomposition:
- Shared package ram_pkg:
  - state enum {ST_IDLE, ST_CLEAR};
  - default width constants DATA_W=4, ADDR_HI_W=4, ADDR_LO_W=8.
- Sub-module ram_clear_seq holds the counter, the FSM and busy. It exposes clr_we, clr_addr and busy.
- ram_sync top muxes the clear write against the user write (clear wins; user accesses are already blocked by busy). It owns the storage array and the read register.

Test Plan:
1. CLEAR_ON_RESET=1, DATA_WIDTH=4, ADDR_HI_WIDTH=2, ADDR_LO_WIDTH=2 (DEPTH=16): pulse reset 2 cycles -> busy=1 for exactly 16 cycles, then 0. A read of every address 0..15 returns 0 with rvalid one cycle after each request.
2. Idle: write 4'hA at oprnd=2'h3, program_byte=2'h1, then read the same address next cycle -> address=4'hD during both accesses; rdata=4'hA, rvalid=1 exactly one cycle after the read edge.
3. Back-to-back: write 1,2,3 to addresses 0,1,2, then read 0,1,2 on consecutive cycles -> rvalid high 3 consecutive cycles with rdata 1,2,3.
4. During clear at cycle 5: chips=1, enableRW=1, wdata=4'hF, address 9 -> rvalid stays 0; after clear completes, a read of 9 returns 0.
5. Assert reset at clear cycle 10, hold 1 cycle -> busy stays 1 and clear restarts. busy falls 16 cycles after reset deasserts.
6. CLEAR_ON_RESET=0 with default widths: busy=0 on the first cycle after reset. Write 4'h5 at 12'hFFF and read it back -> rdata=4'h5. Reset during a pending read -> rvalid=0 and rdata=0.

Source files
------------

// File: rtl/ram_pkg.sv
// Shared types and default widths for the synchronous data RAM.
package ram_pkg;

  typedef enum logic [0:0] {
    ST_IDLE,
    ST_CLEAR
  } state_t;

  localparam int unsigned DATA_W    = 4;
  localparam int unsigned ADDR_HI_W = 4;
  localparam int unsigned ADDR_LO_W = 8;

endpackage

// File: rtl/ram_clear_seq.sv
// Post-reset clear sequencer: walks every address once, writing zero, and
// holds busy high until the final word has been written.
module ram_clear_seq
  import ram_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = ADDR_HI_W + ADDR_LO_W,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic                  clock,
  input  logic                  reset,
  output logic                  clr_we,
  output logic [ADDR_WIDTH-1:0] clr_addr,
  output logic                  busy
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  // One extra bit so DEPTH itself fits; the walk never wraps.
  localparam int unsigned CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);
  localparam state_t RST_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  // State and counter registers; reset restarts the whole clear.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= RST_STATE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: advance one word per cycle, leave after the last word.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_CLEAR: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs: the clear write is active for every cycle spent clearing.
  always_comb begin
    busy     = (state_q == ST_CLEAR);
    clr_we   = busy;
    clr_addr = cnt_q[ADDR_WIDTH-1:0];
  end

endmodule

// File: rtl/ram_sync.sv
// Clocked single-port data RAM with separate write/read data, a registered
// read with a valid strobe, and an optional zeroing pass after reset.
module ram_sync
  import ram_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = DATA_W,
  parameter int unsigned ADDR_HI_WIDTH  = ADDR_HI_W,
  parameter int unsigned ADDR_LO_WIDTH  = ADDR_LO_W,
  parameter bit          CLEAR_ON_RESET = 1'b1,
  localparam int unsigned ADDR_WIDTH    = ADDR_HI_WIDTH + ADDR_LO_WIDTH,
  localparam int unsigned DEPTH         = 2 ** ADDR_WIDTH
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     chips,
  input  logic                     enableRW,
  input  logic [ADDR_HI_WIDTH-1:0] oprnd,
  input  logic [ADDR_LO_WIDTH-1:0] program_byte,
  input  logic [DATA_WIDTH-1:0]    wdata,
  output logic [DATA_WIDTH-1:0]    rdata,
  output logic                     rvalid,
  output logic                     busy,
  output logic [ADDR_WIDTH-1:0]    address
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  clr_we;
  logic [ADDR_WIDTH-1:0] clr_addr;
  logic                  user_wr;
  logic                  user_rd;

  ram_clear_seq #(
    .ADDR_WIDTH     (ADDR_WIDTH),
    .CLEAR_ON_RESET (CLEAR_ON_RESET)
  ) u_clear_seq (
    .clock    (clock),
    .reset    (reset),
    .clr_we   (clr_we),
    .clr_addr (clr_addr),
    .busy     (busy)
  );

  // Address decode and access qualification; busy drops requests outright.
  always_comb begin
    address = {oprnd, program_byte};
    user_wr = chips & enableRW & ~busy & ~reset;
    user_rd = chips & ~enableRW & ~busy & ~reset;
  end

  // Storage write port: the clear pass has priority over user writes.
  always_ff @(posedge clock) begin
    if (clr_we) begin
      mem[clr_addr] <= '0;
    end else if (user_wr) begin
      mem[address] <= wdata;
    end
  end

  // Registered read: one-cycle latency, rdata holds when no read is issued.
  always_ff @(posedge clock) begin
    if (reset) begin
      rdata  <= '0;
      rvalid <= 1'b0;
    end else begin
      rvalid <= user_rd;
      if (user_rd) begin
        rdata <= mem[address];
      end
    end
  end

endmodule

// File: tb/tb_ram_sync.sv
// Bench for ram_sync: a small clearing instance (16 words) and a default-width
// non-clearing instance, checked against array models of the memory.
module tb_ram_sync;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  // Instance A: 16 words, clear on reset.
  logic       a_reset, a_chips, a_rw;
  logic [1:0] a_hi, a_lo;
  logic [3:0] a_wdata, a_rdata, a_address;
  logic       a_rvalid, a_busy;

  // Instance B: default widths, no clear.
  logic        b_reset, b_chips, b_rw;
  logic [3:0]  b_hi;
  logic [7:0]  b_lo;
  logic [3:0]  b_wdata, b_rdata;
  logic [11:0] b_address;
  logic        b_rvalid, b_busy;

  ram_sync #(
    .DATA_WIDTH     (4),
    .ADDR_HI_WIDTH  (2),
    .ADDR_LO_WIDTH  (2),
    .CLEAR_ON_RESET (1'b1)
  ) dut_a (
    .clock        (clock),
    .reset        (a_reset),
    .chips        (a_chips),
    .enableRW     (a_rw),
    .oprnd        (a_hi),
    .program_byte (a_lo),
    .wdata        (a_wdata),
    .rdata        (a_rdata),
    .rvalid       (a_rvalid),
    .busy         (a_busy),
    .address      (a_address)
  );

  ram_sync #(
    .CLEAR_ON_RESET (1'b0)
  ) dut_b (
    .clock        (clock),
    .reset        (b_reset),
    .chips        (b_chips),
    .enableRW     (b_rw),
    .oprnd        (b_hi),
    .program_byte (b_lo),
    .wdata        (b_wdata),
    .rdata        (b_rdata),
    .rvalid       (b_rvalid),
    .busy         (b_busy),
    .address      (b_address)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [3:0] model_a [16];
  logic [3:0] model_b [int];
  logic [3:0] exp_rd_a;
  logic [3:0] exp_rd_b;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // One access cycle on A, checked against the model (outside of any clear).
  task automatic a_op(input bit ch, input bit wr, input int addr, input logic [3:0] d);
    a_chips = ch;
    a_rw    = wr;
    a_hi    = 2'(addr / 4);
    a_lo    = 2'(addr % 4);
    a_wdata = d;
    #1;
    chk("a_address", 16'(a_address), 16'(addr));
    tick();
    if (ch && !wr) begin
      exp_rd_a = model_a[addr];
      chk("a_rvalid_rd", 16'(a_rvalid), 16'd1);
    end else begin
      chk("a_rvalid_idle", 16'(a_rvalid), 16'd0);
    end
    chk("a_rdata", 16'(a_rdata), 16'(exp_rd_a));
    if (ch && wr) model_a[addr] = d;
  endtask

  task automatic b_op(input bit ch, input bit wr, input int addr, input logic [3:0] d);
    b_chips = ch;
    b_rw    = wr;
    b_hi    = 4'(addr / 256);
    b_lo    = 8'(addr % 256);
    b_wdata = d;
    #1;
    chk("b_address", 16'(b_address), 16'(addr));
    tick();
    if (ch && !wr) begin
      exp_rd_b = model_b[addr];
      chk("b_rvalid_rd", 16'(b_rvalid), 16'd1);
    end else begin
      chk("b_rvalid_idle", 16'(b_rvalid), 16'd0);
    end
    chk("b_rdata", 16'(b_rdata), 16'(exp_rd_b));
    if (ch && wr) model_b[addr] = d;
  endtask

  initial begin
    a_reset = 1'b1; a_chips = 1'b0; a_rw = 1'b0; a_hi = '0; a_lo = '0; a_wdata = '0;
    b_reset = 1'b1; b_chips = 1'b0; b_rw = 1'b0; b_hi = '0; b_lo = '0; b_wdata = '0;

    // Reset held two cycles, then the clear must take exactly 16 cycles.
    tick();
    tick();
    chk("rst_busy", 16'(a_busy), 16'd1);
    chk("rst_rvalid", 16'(a_rvalid), 16'd0);
    chk("rst_rdata", 16'(a_rdata), 16'd0);
    a_reset = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk("clr_busy", 16'(a_busy), 16'd1);
      chk("clr_rvalid", 16'(a_rvalid), 16'd0);
      // A write to 9 during the clear must be dropped.
      if (i == 5) begin
        a_chips = 1'b1; a_rw = 1'b1; a_wdata = 4'hF; a_hi = 2'd2; a_lo = 2'd1;
      end else begin
        a_chips = 1'b0;
      end
      tick();
    end
    chk("clr_done_busy", 16'(a_busy), 16'd0);
    for (int i = 0; i < 16; i++) model_a[i] = 4'h0;
    exp_rd_a = 4'h0;

    // Every word reads back zero, back-to-back.
    for (int i = 0; i < 16; i++) a_op(1'b1, 1'b0, i, 4'h0);
    a_op(1'b0, 1'b0, 0, 4'h0);

    // Write then read-next-cycle at address 0xD.
    a_op(1'b1, 1'b1, 13, 4'hA);
    a_op(1'b1, 1'b0, 13, 4'h0);
    chk("t2_rdata", 16'(a_rdata), 16'hA);
    a_op(1'b0, 1'b0, 13, 4'h0);

    // Back-to-back writes and reads.
    for (int i = 0; i < 3; i++) a_op(1'b1, 1'b1, i, 4'(i + 1));
    for (int i = 0; i < 3; i++) a_op(1'b1, 1'b0, i, 4'h0);

    // Randomized traffic against the model.
    for (int i = 0; i < 300; i++) begin
      a_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           int'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    end

    // Reset at clear cycle 10 restarts the full 16-cycle clear.
    a_chips = 1'b0;
    a_reset = 1'b1;
    tick();
    a_reset = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    a_reset = 1'b1;
    tick();
    chk("rerst_busy", 16'(a_busy), 16'd1);
    a_reset = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk("reclr_busy", 16'(a_busy), 16'd1);
      tick();
    end
    chk("reclr_done_busy", 16'(a_busy), 16'd0);
    for (int i = 0; i < 16; i++) model_a[i] = 4'h0;
    exp_rd_a = 4'h0;
    for (int i = 0; i < 16; i++) a_op(1'b1, 1'b0, i, 4'h0);

    // Instance B: no clear, ready straight out of reset.
    tick();
    chk("b_rst_busy", 16'(b_busy), 16'd0);
    b_reset = 1'b0;
    exp_rd_b = 4'h0;
    chk("b_first_busy", 16'(b_busy), 16'd0);
    b_op(1'b1, 1'b1, 4095, 4'h5);
    b_op(1'b1, 1'b0, 4095, 4'h0);
    chk("b_fff_rdata", 16'(b_rdata), 16'h5);
    for (int i = 0; i < 30; i++) begin
      int addr;
      addr = int'($urandom_range(0, 4095));
      b_op(1'b1, 1'b1, addr, 4'($urandom_range(0, 15)));
      b_op(1'b1, 1'b0, addr, 4'h0);
    end
    b_op(1'b1, 1'b0, 4095, 4'h0);

    // Reset arriving with a read request suppresses the read.
    b_chips = 1'b1; b_rw = 1'b0;
    b_reset = 1'b1;
    tick();
    chk("b_rst_rvalid", 16'(b_rvalid), 16'd0);
    chk("b_rst_rdata", 16'(b_rdata), 16'd0);
    b_chips = 1'b0;
    b_reset = 1'b0;
    tick();
    chk("b_post_rvalid", 16'(b_rvalid), 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
